// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant, grant hold
// until release, and an optional MAX_HOLD limit on consecutive grant cycles.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       expire
);

    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] LIMIT = HW'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ptr;
    logic [1:0]      w_ptr_nxt;
    logic [1:0]      r_owner;
    logic [1:0]      w_owner_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_cnt_nxt;
    logic [3:0]      r_gnt;
    logic [3:0]      w_gnt_nxt;
    logic [1:0]      r_gnt_id;
    logic [1:0]      w_gnt_id_nxt;
    logic            r_gnt_valid;
    logic            w_gnt_valid_nxt;
    logic            r_expire;
    logic            w_expire_nxt;
    logic [1:0]      w_winner;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        return (v == {HW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Lowest set bit of req rotated right by the pointer, mapped back to a requester index.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [1:0] pos;
        dbl = {r, r} >> p;
        rot = dbl[3:0];
        pos = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot[i]) pos = 2'(i);
        end
        return pos + p;
    endfunction

    assign w_winner = rr_pick(req, r_ptr);

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_owner_nxt     = r_owner;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_expire_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt     = GRANT;
                    w_owner_nxt     = w_winner;
                    w_gnt_nxt       = 4'b0001 << w_winner;
                    w_gnt_id_nxt    = w_winner;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_cnt_nxt  = HW'(1);
                    w_ptr_nxt       = w_winner + 2'd1;
                end
            end
            GRANT: begin
                // Voluntary release is tested first so it masks a coincident expiry.
                if (!req[r_owner]) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_id_nxt    = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                end else if ((MAX_HOLD != 0) && (r_hold_cnt == LIMIT)) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_id_nxt    = 2'd0;
                    w_gnt_valid_nxt = 1'b0;
                    w_expire_nxt    = 1'b1;
                end else begin
                    w_hold_cnt_nxt  = sat_inc(r_hold_cnt);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = 4'b0000;
                w_gnt_id_nxt    = 2'd0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 2'd0;
            r_owner     <= 2'd0;
            r_hold_cnt  <= '0;
            r_gnt       <= 4'b0000;
            r_gnt_id    <= 2'd0;
            r_gnt_valid <= 1'b0;
            r_expire    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_owner     <= w_owner_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_expire    <= w_expire_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign expire    = r_expire;

endmodule
